// File: rtl/alu_sequencer_if.sv
// Host/Alu-facing bundle of the alu_sequencer: program load, run control, Alu link and status.
// The slave modport is the sequencer's view; master is the host plus Alu side.
interface alu_sequencer_if #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned REPEAT_W = 8
);
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [11:0]         prog_data;
    logic                start;
    logic [ADDR_W-1:0]   length;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic [11:0]         alu_inst;
    logic                alu_inst_en;
    logic [7:0]          alu_result;
    logic [7:0]          result;
    logic                busy;
    logic                done;
    logic                error;

    modport master (
        output prog_we, prog_addr, prog_data, start, length, repeat_cnt, alu_result,
        input  alu_inst, alu_inst_en, result, busy, done, error
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, length, repeat_cnt, alu_result,
        output alu_inst, alu_inst_en, result, busy, done, error
    );
endinterface

// File: rtl/alu_sequencer.sv
// Program sequencer for the 8-bit accumulator Alu: issues RAM-held instructions back-to-back.
// ALU_SEQUENCER_STEP_EN adds a step_i input that gates instruction issue one word per pulse.
module alu_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned REPEAT_W = 8
) (
    input logic clk_i,
    input logic rst_ni,
`ifdef ALU_SEQUENCER_STEP_EN
    input logic step_i,
`endif
    alu_sequencer_if.slave bus
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [11:0] InstClr = 12'h100;

    typedef enum logic [2:0] {StIdle, StClear, StIssue, StDrain, StDone, StErr} state_e;

    state_e              state_q, state_d;
    logic [11:0]         ram_q [Depth];
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [REPEAT_W-1:0] pass_q, pass_d;
    logic [11:0]         inst_q, inst_d;
    logic [7:0]          result_q, result_d;
    logic                error_q, error_d;
    logic                inst_en;
    logic                busy;
    logic                fire;
    logic [11:0]         cur_inst;
    logic                legal;

    assign cur_inst = ram_q[pc_q];
    assign legal    = (cur_inst[11:8] <= 4'h9);
    assign busy     = (state_q == StClear) || (state_q == StIssue) || (state_q == StDrain);

`ifdef ALU_SEQUENCER_STEP_EN
    assign fire = step_i;
`else
    assign fire = 1'b1;
`endif

    // Program RAM has no reset; host writes are only accepted outside a run.
    always_ff @(posedge clk_i) begin
        if (bus.prog_we && !busy) begin
            ram_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        pass_d   = pass_q;
        result_d = result_q;
        error_d  = error_q;
        inst_d   = inst_q;
        inst_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d   = bus.length;
                    pass_d  = bus.repeat_cnt;
                    pc_d    = '0;
                    error_d = 1'b0;
                    state_d = StClear;
                end
            end
            StClear: begin
                inst_d  = InstClr;
                inst_en = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                if (fire) begin
                    if (!legal) begin
                        state_d = StErr;
                    end else begin
                        inst_d  = cur_inst;
                        inst_en = 1'b1;
                        if (pc_q == len_q) begin
                            // Next pass keeps the accumulator; only the pc rewinds.
                            if (pass_q != '0) begin
                                pc_d   = '0;
                                pass_d = pass_q - REPEAT_W'(1);
                            end else begin
                                state_d = StDrain;
                            end
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            StDrain: begin
                // Alu result lags its instruction by one cycle, so it is final here.
                result_d = bus.alu_result;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                error_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            inst_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            pass_q   <= pass_d;
            inst_q   <= inst_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign bus.alu_inst    = inst_d;
    assign bus.alu_inst_en = inst_en;
    assign bus.result      = result_q;
    assign bus.busy        = busy;
    assign bus.done        = (state_q == StDone);
    assign bus.error       = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an accumulator Alu stub and an issued-instruction scoreboard.
module tb_alu_sequencer;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned REPEAT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  acc = 8'h00;

    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_W(ADDR_W), .REPEAT_W(REPEAT_W)) bus ();

`ifdef ALU_SEQUENCER_STEP_EN
    logic step;
    logic step3 = 1'b0;
    int   ph    = 0;
    always @(negedge clk) begin
        ph   = (ph == 2) ? 0 : ph + 1;
        step = step3 ? (ph == 0) : 1'b1;
    end
`endif

    alu_sequencer #(.ADDR_W(ADDR_W), .REPEAT_W(REPEAT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef ALU_SEQUENCER_STEP_EN
        .step_i (step),
`endif
        .bus    (bus)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [11:0] i);
        logic [7:0] m;
        m = i[7:0];
        case (i[11:8])
            4'h1:    return m;
            4'h2:    return a + m;
            4'h3:    return a - m;
            4'h4:    return a & m;
            4'h5:    return a | m;
            4'h6:    return a ^ m;
            4'h7:    return ~a;
            4'h8:    return a << m[2:0];
            4'h9:    return a >> m[2:0];
            default: return a;
        endcase
    endfunction

    // Alu stub: registered accumulator, one-cycle latency.
    always @(posedge clk) if (bus.alu_inst_en) acc <= alu_f(acc, bus.alu_inst);
    assign bus.alu_result = acc;

    // Scoreboard: every issued word must match the next expected one.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && bus.alu_inst_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
            checks++;
            assert (bus.alu_inst === e) else begin
                failures++;
                $error("FAIL issue observed=%h expected=%h", bus.alu_inst, e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int a, input logic [11:0] d);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = ADDR_W'(a);
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic load_t1();
        prog(0, 12'h105);
        prog(1, 12'h203);
        prog(2, 12'h801);
    endtask

    task automatic push_t1();
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h105);
        exp_q.push_back(12'h203);
        exp_q.push_back(12'h801);
    endtask

    task automatic launch(input int len, input int rep);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.length     = ADDR_W'(len);
        bus.repeat_cnt = REPEAT_W'(rep);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // k counts cycles after the start-sampling edge; cycle T+k observed at its negedge.
    task automatic wait_done(input int k0, output int k, output logic seen);
        k    = k0;
        seen = 1'b0;
        while (!seen && k < k0 + 300) begin
            @(negedge clk);
            k++;
            seen = bus.done;
        end
    endtask

    task automatic run_t1(input string tag, input int k0);
        int   k;
        logic seen;
        wait_done(k0, k, seen);
        chk({tag, " done"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(k), 32'd6);
        chk({tag, " result"}, 32'(bus.result), 32'h10);
        chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
        chk({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   k;
        logic seen;
        logic done_seen;

        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.start      = 1'b0;
        bus.length     = '0;
        bus.repeat_cnt = '0;

        #1;
        chk("rst alu_inst", 32'(bus.alu_inst), 32'h0);
        chk("rst alu_inst_en", 32'(bus.alu_inst_en), 32'd0);
        chk("rst result", 32'(bus.result), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst error", 32'(bus.error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: basic three-instruction program
        load_t1();
        push_t1();
        launch(2, 0);
        run_t1("t1", 0);

        // Test 2: single instruction, four passes, no re-clear between passes
        prog(0, 12'h201);
        exp_q.push_back(12'h100);
        repeat (4) exp_q.push_back(12'h201);
        launch(0, 3);
        wait_done(0, k, seen);
        chk("t2 done", 32'(seen), 32'd1);
        chk("t2 latency", 32'(k), 32'd7);
        chk("t2 result", 32'(bus.result), 32'h04);
        chk("t2 drained", 32'(exp_q.size()), 32'd0);

        // Test 3: illegal opcode stops the run before issue
        prog(0, 12'h1AA);
        prog(1, 12'hA00);
        prog(2, 12'h7FF);
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h1AA);
        launch(2, 0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | bus.done;
        end
        @(negedge clk);
        chk("t3 busy@err", 32'(bus.busy), 32'd0);
        done_seen = done_seen | bus.done;
        @(negedge clk);
        done_seen = done_seen | bus.done;
        chk("t3 error", 32'(bus.error), 32'd1);
        chk("t3 no done", 32'(done_seen), 32'd0);
        chk("t3 result held", 32'(bus.result), 32'h04);
        chk("t3 drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3 error sticky", 32'(bus.error), 32'd1);

        // Valid rerun clears the error
        load_t1();
        push_t1();
        launch(2, 0);
        @(negedge clk);
        chk("t3 error cleared", 32'(bus.error), 32'd0);
        run_t1("t3 rerun", 1);

        // Test 4: start and prog_we during ISSUE are ignored
        push_t1();
        launch(2, 0);
        @(negedge clk);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.length     = ADDR_W'(0);
        bus.repeat_cnt = REPEAT_W'(5);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = ADDR_W'(1);
        bus.prog_data  = 12'h9FF;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.prog_we    = 1'b0;
        run_t1("t4", 3);
        push_t1();
        launch(2, 0);
        run_t1("t4 rerun", 0);

        // Test 5: asynchronous reset mid-ISSUE
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h105);
        launch(2, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 inst_en async", 32'(bus.alu_inst_en), 32'd0);
        chk("t5 busy async", 32'(bus.busy), 32'd0);
        chk("t5 alu_inst async", 32'(bus.alu_inst), 32'h0);
        chk("t5 drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_t1();
        launch(2, 0);
        run_t1("t5 rerun", 0);

`ifdef ALU_SEQUENCER_STEP_EN
        // Test 6: stepped issue, one program word per step pulse
        step3 = 1'b1;
        push_t1();
        launch(2, 0);
        wait_done(0, k, seen);
        chk("t6 done", 32'(seen), 32'd1);
        chk("t6 result", 32'(bus.result), 32'h10);
        chk("t6 drained", 32'(exp_q.size()), 32'd0);
        step3 = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
